// File: rtl/spi_pkg.sv
// Shared widths, FSM states and command codes for the command/word SPI master.
package spi_pkg;

  localparam int CMD_WIDTH  = 8;
  localparam int WORD_WIDTH = 32;
  localparam int FRAME_BITS = CMD_WIDTH + WORD_WIDTH;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  localparam logic [CMD_WIDTH-1:0] CMD_READ_R0     = 8'h00;
  localparam logic [CMD_WIDTH-1:0] CMD_WRITE_R0    = 8'h01;
  localparam logic [CMD_WIDTH-1:0] CMD_READ_INV_R0 = 8'h02;

  typedef struct packed {
    logic [CMD_WIDTH-1:0]  cmd;
    logic [WORD_WIDTH-1:0] word;
  } frame_t;

endpackage

// File: rtl/spi_sck_divider.sv
// Generates mode-0 sck from clk: CLK_DIV cycles low, CLK_DIV cycles high, plus phase strobes.
module spi_sck_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise_strobe,
  output logic fall_strobe,
  output logic sample_strobe
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Strobes flag the last cycle of a phase; the edge itself appears on the next cycle.
  assign rise_strobe   = en && wrap && !sck;
  assign fall_strobe   = en && wrap && sck;
  assign sample_strobe = en && wrap && sck;

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: 8-bit command then 32-bit full-duplex word per chip-select frame.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CMD_WIDTH-1:0]  command,
  input  logic [WORD_WIDTH-1:0] word_to_send,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] word_received,
  output logic                  sck,
  output logic                  sdo,
  input  logic                  sdi,
  output logic                  cs
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST       = CW'(CLK_DIV - 1);
  localparam logic [5:0]    LAST_BIT   = 6'(FRAME_BITS - 1);
  localparam logic [5:0]    FIRST_DATA = 6'(CMD_WIDTH);

  state_t                  state, state_nx;
  logic [CW-1:0]           hcnt;
  logic [5:0]              bit_cnt;
  logic                    first_rise;
  logic [FRAME_BITS-1:0]   shift;
  logic [WORD_WIDTH-1:0]   rx, word_q;
  logic [1:0]              sdi_sync;
  logic                    rise_strobe, fall_strobe, sample_strobe;
  logic                    accept;
  frame_t                  req;

  assign req    = '{cmd: command, word: word_to_send};
  assign accept = (state == IDLE) && start;

  spi_sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (state == SHIFT),
    .sck           (sck),
    .rise_strobe   (rise_strobe),
    .fall_strobe   (fall_strobe),
    .sample_strobe (sample_strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (fall_strobe && bit_cnt == LAST_BIT) state_nx = HOLD;
      HOLD:    if (hcnt == LAST) state_nx = GAP;
      GAP:     if (hcnt == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cs   = 1'b1;
    busy = 1'b0;
    done = 1'b0;
    sdo  = 1'b0;
    unique case (state)
      SHIFT, HOLD: begin
        cs   = 1'b0;
        busy = 1'b1;
        sdo  = shift[FRAME_BITS-1];
      end
      GAP: begin
        busy = 1'b1;
        done = (hcnt == LAST);
      end
      default: ;
    endcase
  end

  // HOLD/GAP phase timer; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            hcnt <= '0;
    else if (state_nx != state)            hcnt <= '0;
    else if (state == HOLD || state == GAP) hcnt <= hcnt + 1'b1;
  end

  // bit_cnt holds the index of the bit whose high phase is current (0..39).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift      <= '0;
      bit_cnt    <= '0;
      first_rise <= 1'b0;
    end else if (accept) begin
      shift      <= req;
      bit_cnt    <= '0;
      first_rise <= 1'b1;
    end else if (state == SHIFT) begin
      if (rise_strobe) begin
        first_rise <= 1'b0;
        if (!first_rise) bit_cnt <= bit_cnt + 6'd1;
      end
      // The last bit stays on sdo through HOLD.
      if (fall_strobe && bit_cnt != LAST_BIT) shift <= shift << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sdi_sync <= '0;
    else        sdi_sync <= {sdi_sync[0], sdi};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx     <= '0;
      word_q <= '0;
    end else begin
      if (state == SHIFT && sample_strobe && bit_cnt >= FIRST_DATA)
        rx <= {rx[WORD_WIDTH-2:0], sdi_sync[1]};
      if (done) word_q <= rx;
    end
  end

  assign word_received = done ? rx : word_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench: three CLK_DIV instances, a register-file slave model on the CLK_DIV=4 one.
module tb_spi_master;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  logic start2 = 0, start4 = 0, start1 = 0;
  logic [7:0]  cmd2 = 0, cmd4 = 0, cmd1 = 0;
  logic [31:0] w2 = 0, w4 = 0, w1 = 0;
  logic busy2, done2, sck2, sdo2, cs2;
  logic busy4, done4, sck4, sdo4, cs4;
  logic busy1, done1, sck1, sdo1, cs1;
  logic [31:0] wr2, wr4, wr1;
  logic sdi2, sdi1;
  logic sdi4 = 1'b0;
  assign sdi2 = 1'b1;
  assign sdi1 = 1'b0;

  spi_master #(.CLK_DIV(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(start2), .command(cmd2),
    .word_to_send(w2), .busy(busy2), .done(done2), .word_received(wr2), .sck(sck2),
    .sdo(sdo2), .sdi(sdi2), .cs(cs2));
  spi_master #(.CLK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .command(cmd4),
    .word_to_send(w4), .busy(busy4), .done(done4), .word_received(wr4), .sck(sck4),
    .sdo(sdo4), .sdi(sdi4), .cs(cs4));
  spi_master #(.CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .command(cmd1),
    .word_to_send(w1), .busy(busy1), .done(done1), .word_received(wr1), .sck(sck1),
    .sdo(sdo1), .sdi(sdi1), .cs(cs1));

  // Monitors (negedge, away from the active edge)
  logic sck2_q = 0;
  int rise2 = 0, cslow2 = 0, dn2 = 0, dn2_cyc = 0;
  logic [39:0] strm2 = '0;
  logic [31:0] wr2_dn = '0;
  always @(negedge clk) begin
    if (sck2 && !sck2_q) begin rise2++; strm2 = {strm2[38:0], sdo2}; end
    sck2_q = sck2;
    if (!cs2) cslow2++;
    if (done2) begin dn2++; dn2_cyc = cyc; wr2_dn = wr2; end
  end

  int dn4 = 0;
  logic [31:0] wr4_dn = '0;
  always @(negedge clk) if (done4) begin dn4++; wr4_dn = wr4; end

  logic cs1_q = 1;
  int hi1 = 0;
  int dn1_q[$];
  int gap1_q[$];
  always @(negedge clk) begin
    if (done1) dn1_q.push_back(cyc);
    if (cs1) hi1++;
    else begin
      if (cs1_q) gap1_q.push_back(hi1);
      hi1 = 0;
    end
    cs1_q = cs1;
  end

  // Register-file slave seen through a 2-flop synchronizer on sck.
  logic [2:0]  ssck = '0;
  logic        scs = 1'b1;
  int          scnt = 0;
  logic [39:0] srx = '0;
  logic [31:0] stx = '0;
  logic [31:0] r0 = 32'h12345678;
  logic [7:0]  scmd = '0;

  function automatic logic [31:0] slave_word(input logic [7:0] c, input logic [31:0] r);
    case (c)
      CMD_READ_R0:     return r;
      CMD_READ_INV_R0: return ~r;
      default:         return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    ssck <= {ssck[1:0], sck4};
    scs  <= cs4;
    if (cs4) begin
      scnt <= 0;
      sdi4 <= 1'b0;
      if (!scs && scmd == CMD_WRITE_R0 && scnt == 40) r0 <= srx[31:0];
    end else begin
      if (ssck[1] && !ssck[2]) begin
        srx  <= {srx[38:0], sdo4};
        scnt <= scnt + 1;
        if (scnt == 7) begin
          scmd <= {srx[6:0], sdo4};
          stx  <= slave_word({srx[6:0], sdo4}, r0);
        end
      end
      if (!ssck[1] && ssck[2] && scnt >= 8) begin
        sdi4 <= stx[31];
        stx  <= {stx[30:0], 1'b0};
      end
    end
  end

  task automatic run4(input logic [7:0] c, input logic [31:0] w);
    @(negedge clk); cmd4 = c; w4 = w; start4 = 1;
    @(negedge clk); start4 = 0;
    repeat (340) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_chk++; if (cs2 !== 1'b1) $display("FAIL reset_cs got %b want 1", cs2); else n_pass++;
    n_chk++; if (sck2 !== 1'b0) $display("FAIL reset_sck got %b want 0", sck2); else n_pass++;
    n_chk++; if (sdo2 !== 1'b0) $display("FAIL reset_sdo got %b want 0", sdo2); else n_pass++;
    n_chk++; if (busy2 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy2); else n_pass++;
    n_chk++; if (done2 !== 1'b0) $display("FAIL reset_done got %b want 0", done2); else n_pass++;
    n_chk++; if (wr2 !== 32'h0) $display("FAIL reset_word got %h want 0", wr2); else n_pass++;
    n_chk++; if ({cs4, busy4, sck4, cs1, busy1, sck1, sdo1} !== 7'b1001000)
      $display("FAIL reset_others got %b want 1001000", {cs4, busy4, sck4, cs1, busy1, sck1, sdo1});
    else n_pass++;
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int t0, b_rise, b_cs, b_dn;
    logic hold_sdo, gap_sdo, gap_cs;
    hold_sdo = 0; gap_sdo = 1; gap_cs = 0;
    @(negedge clk); cmd2 = 8'h01; w2 = 32'hDEADBEEF; start2 = 1;
    t0 = cyc; b_rise = rise2; b_cs = cslow2; b_dn = dn2;
    @(negedge clk); start2 = 0;
    n_chk++; if ({cs2, busy2, sdo2} !== 3'b010)
      $display("FAIL basic_start got cs/busy/sdo=%b want 010", {cs2, busy2, sdo2}); else n_pass++;
    for (int i = 2; i <= 170; i++) begin
      @(negedge clk);
      if (i == 161) hold_sdo = sdo2;
      if (i == 163) begin gap_sdo = sdo2; gap_cs = cs2; end
    end
    n_chk++; if (rise2 - b_rise != 40) $display("FAIL basic_rises got %0d want 40", rise2 - b_rise); else n_pass++;
    n_chk++; if (strm2 !== 40'h01DEADBEEF) $display("FAIL basic_stream got %h want 01deadbeef", strm2); else n_pass++;
    n_chk++; if (cslow2 - b_cs != 162) $display("FAIL basic_cs_low got %0d want 162", cslow2 - b_cs); else n_pass++;
    n_chk++; if (dn2 - b_dn != 1) $display("FAIL basic_done_cnt got %0d want 1", dn2 - b_dn); else n_pass++;
    n_chk++; if (dn2_cyc != t0 + 164) $display("FAIL basic_done_time got %0d want %0d", dn2_cyc, t0 + 164); else n_pass++;
    n_chk++; if (wr2_dn !== 32'hFFFFFFFF) $display("FAIL basic_word got %h want ffffffff", wr2_dn); else n_pass++;
    n_chk++; if (hold_sdo !== 1'b1) $display("FAIL basic_hold_sdo got %b want 1", hold_sdo); else n_pass++;
    n_chk++; if ({gap_cs, gap_sdo} !== 2'b10) $display("FAIL basic_gap got cs/sdo=%b want 10", {gap_cs, gap_sdo}); else n_pass++;
    n_chk++; if (busy2 !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy2); else n_pass++;
  endtask

  task automatic test_slave_read;
    int b;
    b = dn4;
    run4(CMD_READ_R0, 32'hCAFEF00D);
    n_chk++; if (dn4 - b != 1) $display("FAIL read_done_cnt got %0d want 1", dn4 - b); else n_pass++;
    n_chk++; if (wr4_dn !== 32'h12345678) $display("FAIL read_word got %h want 12345678", wr4_dn); else n_pass++;
    n_chk++; if (wr4 !== 32'h12345678) $display("FAIL read_word_held got %h want 12345678", wr4); else n_pass++;
  endtask

  task automatic test_write_readback;
    run4(CMD_WRITE_R0, 32'hA5A50F0F);
    n_chk++; if (r0 !== 32'hA5A50F0F) $display("FAIL wr_slave_reg got %h want a5a50f0f", r0); else n_pass++;
    run4(CMD_READ_R0, 32'h0);
    n_chk++; if (wr4_dn !== 32'hA5A50F0F) $display("FAIL wr_readback got %h want a5a50f0f", wr4_dn); else n_pass++;
    run4(CMD_READ_INV_R0, 32'h0);
    n_chk++; if (wr4_dn !== 32'h5A5AF0F0) $display("FAIL wr_read_inv got %h want 5a5af0f0", wr4_dn); else n_pass++;
    n_chk++; if (busy4 !== 1'b0) $display("FAIL wr_busy_end got %b want 0", busy4); else n_pass++;
  endtask

  task automatic test_start_while_busy;
    int b_rise, b_dn;
    @(negedge clk); cmd2 = 8'h02; w2 = 32'h13579BDF; start2 = 1;
    b_rise = rise2; b_dn = dn2;
    @(negedge clk); start2 = 0;
    repeat (9) @(negedge clk);
    cmd2 = 8'hFF; w2 = 32'h0; start2 = 1;
    @(negedge clk); start2 = 0;
    repeat (200) @(negedge clk);
    n_chk++; if (rise2 - b_rise != 40) $display("FAIL busy_rises got %0d want 40", rise2 - b_rise); else n_pass++;
    n_chk++; if (strm2 !== 40'h0213579BDF) $display("FAIL busy_stream got %h want 0213579bdf", strm2); else n_pass++;
    n_chk++; if (dn2 - b_dn != 1) $display("FAIL busy_done_cnt got %0d want 1", dn2 - b_dn); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int b_rise, b_dn;
    @(negedge clk); cmd2 = 8'h01; w2 = 32'h0F1E2D3C; start2 = 1;
    b_rise = rise2; b_dn = dn2;
    @(negedge clk); start2 = 0;
    repeat (81) @(negedge clk);
    n_chk++; if (rise2 - b_rise != 20) $display("FAIL mid_rises_before got %0d want 20", rise2 - b_rise); else n_pass++;
    rst_n = 0;
    #1;
    n_chk++; if ({cs2, sck2, busy2} !== 3'b100)
      $display("FAIL mid_reset got cs/sck/busy=%b want 100", {cs2, sck2, busy2}); else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (200) @(negedge clk);
    n_chk++; if (dn2 - b_dn != 0) $display("FAIL mid_no_done got %0d want 0", dn2 - b_dn); else n_pass++;
    @(negedge clk); cmd2 = 8'hC3; w2 = 32'h600DF00D; start2 = 1;
    b_dn = dn2;
    @(negedge clk); start2 = 0;
    repeat (170) @(negedge clk);
    n_chk++; if (strm2 !== 40'hC3600DF00D) $display("FAIL mid_next_stream got %h want c3600df00d", strm2); else n_pass++;
    n_chk++; if (dn2 - b_dn != 1) $display("FAIL mid_next_done got %0d want 1", dn2 - b_dn); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int t0, bdn, bgap;
    int d[3];
    int g[3];
    bdn = dn1_q.size(); bgap = gap1_q.size();
    @(negedge clk); cmd1 = 8'h02; w1 = 32'h89ABCDEF; start1 = 1; t0 = cyc;
    repeat (168) @(negedge clk);
    start1 = 0;
    repeat (120) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      d[k] = (dn1_q.size() > bdn + k) ? dn1_q[bdn + k] : -1000;
      g[k] = (gap1_q.size() > bgap + k) ? gap1_q[bgap + k] : -1;
    end
    n_chk++; if (dn1_q.size() - bdn != 3) $display("FAIL b2b_done_cnt got %0d want 3", dn1_q.size() - bdn); else n_pass++;
    n_chk++; if (d[0] != t0 + 82) $display("FAIL b2b_first_done got %0d want %0d", d[0], t0 + 82); else n_pass++;
    n_chk++; if (d[1] - d[0] != 83) $display("FAIL b2b_spacing1 got %0d want 83", d[1] - d[0]); else n_pass++;
    n_chk++; if (d[2] - d[1] != 83) $display("FAIL b2b_spacing2 got %0d want 83", d[2] - d[1]); else n_pass++;
    n_chk++; if (gap1_q.size() - bgap != 3) $display("FAIL b2b_frames got %0d want 3", gap1_q.size() - bgap); else n_pass++;
    n_chk++; if (g[1] != 2 || g[2] != 2) $display("FAIL b2b_cs_gap got %0d,%0d want 2,2", g[1], g[2]); else n_pass++;
    n_chk++; if ({busy1, wr1} !== 33'h0) $display("FAIL b2b_end got busy=%b word=%h want 0/0", busy1, wr1); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_slave_read;
    test_write_readback;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI master for the simple command/word SPI protocol: one 8-bit command followed by one 32-bit full-duplex data word per chip-select frame. The host logic, for example an FPGA-side test driver or a bridge to the register-file slave, issues `start` with a command and an outgoing word. The block then generates `cs`, `sck` and `sdo`, and returns the 32 bits captured on `sdi`. Signalling is mode 0: MSB first, `sdo` changes while `sck` is low, and the slave samples on the `sck` rising edge.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `sck` half-period. Legal values are 1 or more; the `sck` frequency is clk/(2·CLK_DIV).
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a transfer. It is accepted only when `busy`=0.
- `command`, input, 8: command byte. Captured when `start` is accepted.
- `word_to_send`, input, 32: data word. Captured when `start` is accepted.
- `busy`, output, 1: high from the cycle after acceptance through the `done` cycle.
- `done`, output, 1: one-cycle pulse when the transfer is complete.
- `word_received`, output, 32: the 32 `sdi` bits captured during the word phase. Updated in the `done` cycle and held until the next `done`.
- `sck`, output, 1: SPI clock. Idles low.
- `sdo`, output, 1: master-out data.
- `sdi`, input, 1: master-in data. Asynchronous to `clk`.
- `cs`, output, 1: chip select, active low. Idles high.

## Operation
- **Reset values:** `cs`=1, `sck`=0, `sdo`=0, `busy`=0, `done`=0, `word_received`=0, state IDLE. Reset mid-frame aborts the frame immediately with no `done`; the slave sees `cs` rise.
- **Frame structure:** a 40-bit shift register is loaded with {`command`, `word_to_send`}. 40 bits are sent MSB first.
- **IDLE:** `start`=1 latches the operands, sets `busy`, and moves to SHIFT.
- **SHIFT:**
  - `cs`=0 and `sdo`=shift[39].
  - Each bit consists of CLK_DIV cycles with `sck` low, then CLK_DIV cycles with `sck` high.
  - On the high-to-low transition the shift register shifts left by 1.
  - After the 40th high phase the state moves to HOLD, with `sck` low.
- **`sdi` sampling:**
  - `sdi` is passed through a 2-flop synchronizer.
  - The synchronized value is sampled in the last `clk` cycle of each `sck`-high phase, not at the rising edge. This gives the slave's synchronizer and output path up to CLK_DIV−1 cycles of latency.
  - Bits 0–7 (the command phase) are discarded.
  - Bits 8–39 are shifted into the receive register, MSB first.
- **HOLD:** `cs`=0 and `sck`=0 for CLK_DIV cycles, then move to GAP.
- **GAP:** `cs`=1 for CLK_DIV cycles. In the final GAP cycle `done`=1 and `word_received` is loaded. The state returns to IDLE and `busy`=0 on the next cycle.
- **Counters:**
  - The half-period counter is $clog2(CLK_DIV+1) bits wide and wraps at CLK_DIV−1.
  - The bit counter is 6 bits wide and counts 0..39.
- **Boundary conditions:**
  - `start` while `busy` is ignored and not queued.
  - `start` held high continuously yields back-to-back frames, separated by the GAP plus one IDLE cycle.
  - Operand changes while `busy` have no effect.
  - `sdo` stays at the last bit value during HOLD and returns to 0 in GAP.

## Timing
- Let t0 be the cycle in which `start` is accepted.
- t0+1: `cs` falls, `busy` rises, `sdo` presents command bit 7.
- Bit n (0..39):
  - `sck` rises at t0+1+(2n+1)·CLK_DIV.
  - `sck` falls at t0+1+(2n+2)·CLK_DIV.
- `cs` rises at t0+1+81·CLK_DIV.
- `done` pulses at t0+82·CLK_DIV. `busy` falls at t0+1+82·CLK_DIV.
- Total frame length is 82·CLK_DIV+1 cycles. The earliest next acceptance is at t0+1+82·CLK_DIV.
- `sdi` must be stable at least 2 `clk` cycles before the end of its `sck`-high phase.

## Structure
- Package `spi_pkg`:
  - `CMD_WIDTH`=8, `WORD_WIDTH`=32, `FRAME_BITS`=40.
  - State enum {IDLE, SHIFT, HOLD, GAP}.
  - Command codes: `CMD_READ_R0`=8'h00, `CMD_WRITE_R0`=8'h01, `CMD_READ_INV_R0`=8'h02.
- Sub-module `spi_sck_divider`:
  - Half-period counter.
  - Produces `sck`, a `rise_strobe`, a `fall_strobe`, and a `sample_strobe` (the last cycle of the high phase).
  - Enabled only in SHIFT.
- The FSM, shift registers and `sdi` synchronizer live in `spi_master`.

## Test plan
- **Basic frame, CLK_DIV=2:** `command`=8'h01 and `word_to_send`=32'hDEADBEEF. Expect:
  - 40 `sck` rising edges, with the sampled `sdo` stream equal to 40'h01DEADBEEF;
  - `cs` low for exactly 162 cycles;
  - `done` at t0+164.
- **Read via slave model, CLK_DIV=4:** the slave model returns 32'h12345678 with 2-cycle synchronizer latency for `CMD_READ_R0`. Expect `word_received`=32'h12345678 at `done`.
- **Write/readback against the register-file slave:**
  - Write 32'hA5A5_0F0F with `CMD_WRITE_R0`.
  - `CMD_READ_R0` then returns 32'hA5A5_0F0F.
  - `CMD_READ_INV_R0` then returns 32'h5A5A_F0F0.
- **Start while busy:** pulse `start` at t0+10 with different operands. Expect the frame bits unchanged, a single `done`, and no second frame.
- **Reset mid-frame:** assert `rst_n`=0 at bit 20. Expect:
  - `cs`=1, `sck`=0, `busy`=0 in the same cycle;
  - no `done`;
  - the next frame is correct.
- **CLK_DIV=1 back-to-back:** hold `start` high for 3 frames. Expect 3 `done` pulses spaced 83 cycles apart, and `cs` high for at least 2 cycles between frames.
